// File: rtl/cell_chk_pkg.sv
// Shared types, constants and cell models for the cell truth-table checker.
// Contents: cell_sel_e (selection codes 0..9), chk_state_e (sequencer states),
// cell_arity / cell_last_vec / cell_valid / cell_golden helper functions.
package cell_chk_pkg;

  localparam int unsigned CELL_NUM = 10;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned VEC_W    = 4;
  localparam int unsigned ERR_W    = 5;
  localparam int unsigned ARITY_W  = 3;

  typedef enum logic [SEL_W-1:0] {
    CELL_INV_1   = 4'd0,
    CELL_NAND2_1 = 4'd1,
    CELL_NAND3_1 = 4'd2,
    CELL_NAND4_1 = 4'd3,
    CELL_NOR2_1  = 4'd4,
    CELL_NOR3_1  = 4'd5,
    CELL_AOI21_1 = 4'd6,
    CELL_AOI22_1 = 4'd7,
    CELL_OAI21_1 = 4'd8,
    CELL_OAI22_1 = 4'd9
  } cell_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } chk_state_e;

  // Selection codes 10..15 do not name a cell.
  function automatic logic cell_valid(input logic [SEL_W-1:0] sel);
    return (32'(sel) < CELL_NUM);
  endfunction

  // Number of inputs of the selected cell; 0 for an invalid selection.
  function automatic logic [ARITY_W-1:0] cell_arity(input logic [SEL_W-1:0] sel);
    logic [ARITY_W-1:0] ar;
    ar = 3'd0;
    case (sel)
      CELL_INV_1:   ar = 3'd1;
      CELL_NAND2_1: ar = 3'd2;
      CELL_NAND3_1: ar = 3'd3;
      CELL_NAND4_1: ar = 3'd4;
      CELL_NOR2_1:  ar = 3'd2;
      CELL_NOR3_1:  ar = 3'd3;
      CELL_AOI21_1: ar = 3'd3;
      CELL_AOI22_1: ar = 3'd4;
      CELL_OAI21_1: ar = 3'd3;
      CELL_OAI22_1: ar = 3'd4;
      default:      ar = 3'd0;
    endcase
    return ar;
  endfunction

  // All-ones vector for the given arity (2^arity - 1).
  function automatic logic [VEC_W-1:0] cell_last_vec(input logic [ARITY_W-1:0] ar);
    return VEC_W'((5'd1 << ar) - 5'd1);
  endfunction

  // Golden cell output; vec bit i is cell input in<i>.
  function automatic logic cell_golden(input logic [SEL_W-1:0] sel,
                                       input logic [VEC_W-1:0] vec);
    logic y;
    y = 1'b0;
    case (sel)
      CELL_INV_1:   y = ~vec[0];
      CELL_NAND2_1: y = ~(vec[0] & vec[1]);
      CELL_NAND3_1: y = ~(vec[0] & vec[1] & vec[2]);
      CELL_NAND4_1: y = ~(vec[0] & vec[1] & vec[2] & vec[3]);
      CELL_NOR2_1:  y = ~(vec[0] | vec[1]);
      CELL_NOR3_1:  y = ~(vec[0] | vec[1] | vec[2]);
      CELL_AOI21_1: y = ~((vec[0] & vec[1]) | vec[2]);
      CELL_AOI22_1: y = ~((vec[0] & vec[1]) | (vec[2] & vec[3]));
      CELL_OAI21_1: y = ~((vec[0] | vec[1]) & vec[2]);
      CELL_OAI22_1: y = ~((vec[0] | vec[1]) & (vec[2] | vec[3]));
      default:      y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/cell_golden_model.sv
// Combinational golden model of the selected library cell.
// Ports: sel_i (cell selection), vec_i (cell input vector),
//        golden_o_c (expected cell output, combinational).
module cell_golden_model
  import cell_chk_pkg::*;
(
  input  logic [SEL_W-1:0] sel_i,
  input  logic [VEC_W-1:0] vec_i,
  output logic             golden_o_c
);

  always_comb golden_o_c = cell_golden(sel_i, vec_i);

endmodule

// File: rtl/cell_truth_checker.sv
// Exhaustive truth-table sequencer for one combinational library cell.
// Drives every input vector of the selected cell, waits SETTLE_CYCLES,
// samples dut_out and compares it with the golden model.
// Ports: clk, rst (sync, active-high), start, cell_sel -> vec_out to the cell,
//        dut_out from the cell; busy, done, pass, bad_sel, err_count, fail_vec.
// Build option: CELL_CHK_STOP_ON_FAIL_EN ends the run at the first mismatch.
module cell_truth_checker
  import cell_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] cell_sel,
  output logic [VEC_W-1:0] vec_out,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             bad_sel,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] fail_vec
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = ERR_W'(16);

  chk_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [VEC_W-1:0] vec_q,   vec_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             pass_q,  pass_d;
  logic             bad_q,   bad_d;
  logic [ERR_W-1:0] err_q,   err_d;
  logic [VEC_W-1:0] fvec_q,  fvec_d;

  logic             golden;
  logic             mismatch;
  logic             stop;
  logic [ERR_W-1:0] err_nx;

  cell_golden_model u_golden (
    .sel_i      (sel_q),
    .vec_i      (vec_q),
    .golden_o_c (golden)
  );

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      bad_q   <= 1'b0;
      err_q   <= '0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
    end
  end

  // Next-state and result update.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    bad_d    = bad_q;
    err_d    = err_q;
    fvec_d   = fvec_q;
    mismatch = (dut_out != golden);
    err_nx   = err_q;
    stop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d  = cell_sel;
          pass_d = 1'b0;
          bad_d  = 1'b0;
          err_d  = '0;
          fvec_d = '0;
          vec_d  = '0;
          cnt_d  = '0;
          if (cell_valid(cell_sel)) begin
            state_d = ST_SETTLE;
          end else begin
            bad_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          err_nx = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);
          if (err_q == '0) fvec_d = vec_q;
        end
        err_d = err_nx;
        stop  = (vec_q == cell_last_vec(cell_arity(sel_q)));
`ifdef CELL_CHK_STOP_ON_FAIL_EN
        stop  = stop | mismatch;
`endif
        if (stop) begin
          // pass is resolved on DONE entry so it is already valid while done is high.
          pass_d  = (err_nx == '0) && !bad_q;
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + VEC_W'(1);
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        vec_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign vec_out   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign bad_sel   = bad_q;
  assign err_count = err_q;
  assign fail_vec  = fvec_q;

endmodule

// File: tb/tb_cell_truth_checker.sv
// Scoreboard bench for cell_truth_checker: the cell under test is modelled
// in the bench (correct, stuck-at-0, stuck-at-1 or inverted).
module tb_cell_truth_checker;

  localparam int unsigned S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] cell_sel;
  logic [3:0] vec_out;
  logic       dut_out;
  logic       busy, done, pass, bad_sel;
  logic [4:0] err_count;
  logic [3:0] fail_vec;

  logic [1:0] dut_mode;   // 0 correct, 1 stuck-0, 2 stuck-1, 3 inverted
  logic [3:0] tb_sel;

  int n_vec = 0;
  int n_err = 0;
  int arity_tab [10] = '{1, 2, 3, 4, 2, 3, 3, 4, 3, 4};

  typedef struct { int cyc; int vec; } vec_exp_t;
  typedef struct { int cyc; logic pass; int err; int fvec; logic bad; } res_exp_t;
  vec_exp_t vec_q[$];
  res_exp_t res_q[$];

  always #5 clk = ~clk;

  function automatic logic ref_out(input logic [3:0] sel, input logic [3:0] v);
    case (sel)
      4'd0: return !v[0];
      4'd1: return !(v[0] && v[1]);
      4'd2: return !(v[0] && v[1] && v[2]);
      4'd3: return !(v == 4'hF);
      4'd4: return !(v[0] || v[1]);
      4'd5: return !(v[0] || v[1] || v[2]);
      4'd6: return !((v[0] && v[1]) || v[2]);
      4'd7: return !((v[0] && v[1]) || (v[2] && v[3]));
      4'd8: return !((v[0] || v[1]) && v[2]);
      4'd9: return !((v[0] || v[1]) && (v[2] || v[3]));
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic model_out(input logic [1:0] mode, input logic [3:0] sel,
                                     input logic [3:0] v);
    case (mode)
      2'd0: return ref_out(sel, v);
      2'd1: return 1'b0;
      2'd2: return 1'b1;
      default: return !ref_out(sel, v);
    endcase
  endfunction

  assign dut_out = model_out(dut_mode, tb_sel, vec_out);

  cell_truth_checker #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cell_sel  (cell_sel),
    .vec_out   (vec_out),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .bad_sel   (bad_sel),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".vec_out"},   32'(vec_out),   0);
    chk({tag, ".busy"},      32'(busy),      0);
    chk({tag, ".done"},      32'(done),      0);
    chk({tag, ".pass"},      32'(pass),      0);
    chk({tag, ".bad_sel"},   32'(bad_sel),   0);
    chk({tag, ".err_count"}, 32'(err_count), 0);
    chk({tag, ".fail_vec"},  32'(fail_vec),  0);
  endtask

  // One run: push expectations, pulse start, then walk the run cycle by cycle.
  task automatic run(input int sel, input logic [1:0] mode, input int restart_at,
                     input int rst_at);
    int ar, n, errs, first_fail, last_k, done_cyc, cyc;
    logic aborted;
    res_exp_t r;
    vec_exp_t ve;

    tb_sel   = 4'(sel);
    dut_mode = mode;
    aborted  = 1'b0;
    if (sel < 10) begin
      ar = arity_tab[sel];
      n  = 1 << ar;
      errs = 0; first_fail = -1; last_k = n - 1;
      for (int k = 0; k < n; k++) begin
        logic mism;
        vec_q.push_back('{cyc: (k + 1) * (S + 1), vec: k});
        mism = (model_out(mode, 4'(sel), 4'(k)) != ref_out(4'(sel), 4'(k)));
        if (mism) begin
          errs++;
          if (first_fail < 0) first_fail = k;
        end
`ifdef CELL_CHK_STOP_ON_FAIL_EN
        if (mism) begin
          last_k = k;
          break;
        end
`endif
      end
      done_cyc = (last_k + 1) * (S + 1) + 1;
      r = '{cyc: done_cyc, pass: (errs == 0), err: errs,
            fvec: (first_fail < 0) ? 0 : first_fail, bad: 1'b0};
    end else begin
      ar = 0;
      done_cyc = 1;
      r = '{cyc: 1, pass: 1'b0, err: 0, fvec: 0, bad: 1'b1};
    end
    if (rst_at == 0) res_q.push_back(r);

    @(negedge clk);
    cell_sel = 4'(sel);
    start    = 1'b1;
    @(posedge clk);             // end of cycle 0
    @(negedge clk);
    start    = 1'b0;
    cell_sel = 4'd10;           // later changes of cell_sel must not matter
    cyc = 1;

    while (cyc <= done_cyc + ((rst_at != 0) ? 3 : 1)) begin
      start = (cyc == restart_at);
      if (cyc == restart_at) cell_sel = 4'd12;
      if (rst_at != 0 && cyc == rst_at) rst = 1'b1;
      if (rst_at != 0 && cyc == rst_at + 1) begin
        rst = 1'b0;
        aborted = 1'b1;
        chk_all_zero("after_rst");
        vec_q.delete();
      end

      if (aborted) begin
        chk("no_done_after_rst", 32'(done), 0);
        chk("idle_after_rst",    32'(busy), 0);
      end else if (cyc <= done_cyc) begin
        chk("vec_hi_zero", 32'(vec_out) >> ar, 0);
        chk("busy", 32'(busy), 1);
        chk("done", 32'(done), (cyc == done_cyc) ? 1 : 0);
        if (vec_q.size() > 0 && vec_q[0].cyc == cyc) begin
          ve = vec_q.pop_front();
          chk("vec_out", 32'(vec_out), 32'(ve.vec));
        end
        if (cyc == done_cyc && res_q.size() > 0) begin
          r = res_q.pop_front();
          chk("pass",      32'(pass),      32'(r.pass));
          chk("err_count", 32'(err_count), 32'(r.err));
          chk("fail_vec",  32'(fail_vec),  32'(r.fvec));
          chk("bad_sel",   32'(bad_sel),   32'(r.bad));
        end
      end else begin
        chk("done_pulse_end", 32'(done),    0);
        chk("busy_end",       32'(busy),    0);
        chk("vec_out_end",    32'(vec_out), 0);
        chk("pass_hold",      32'(pass),    32'(r.pass));
        chk("err_hold",       32'(err_count), 32'(r.err));
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!aborted) chk("vec_q_drained", 32'(vec_q.size()), 0);
    vec_q.delete();
    res_q.delete();
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    cell_sel = 4'd0;
    dut_mode = 2'd0;
    tb_sel   = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    run(1, 2'd0, 0, 0);   // nand2 correct
    run(1, 2'd1, 0, 0);   // nand2 stuck-0
    run(1, 2'd2, 0, 0);   // nand2 stuck-1: only vector 3 fails
    run(7, 2'd0, 0, 0);   // aoi22 correct, 16 vectors
    run(0, 2'd0, 0, 0);   // inv correct
    run(12, 2'd0, 0, 0);  // invalid selection
    run(8, 2'd0, 5, 0);   // oai21 with ignored start at cycle 5
    run(9, 2'd0, 0, 6);   // oai22 reset mid-run
    run(9, 2'd0, 0, 0);   // oai22 normal after reset
    run(3, 2'd3, 0, 0);   // nand4 inverted: every vector fails
    run(6, 2'd1, 0, 0);   // aoi21 stuck-0

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cell_truth_checker.md
# cell_truth_checker

Sequencer that exhaustively exercises one combinational library cell (inv_1 … oai22_1) at a time. It drives every input vector for the selected cell's arity, waits a programmable settle time, samples the cell output and compares it against an internal golden model. It reports pass/fail, the mismatch count and the first failing vector. It sits in the cell-library self-test harness, with the cell under test wired to `vec_out`/`dut_out`.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run; honoured only in IDLE.
- `cell_sel` in 4: 0 inv_1, 1 nand2_1, 2 nand3_1, 3 nand4_1, 4 nor2_1, 5 nor3_1, 6 aoi21_1, 7 aoi22_1, 8 oai21_1, 9 oai22_1; 10..15 invalid. Captured on accepted `start`.
- `vec_out` out 4: cell inputs; bit i drives `in<i>`; bits at or above the arity are held 0.
- `dut_out` in 1: cell output under test.
- `busy` out 1: high from the cycle after `start` is accepted through the DONE cycle.
- `done` out 1: one-cycle pulse at end of run.
- `pass` out 1: run finished with zero mismatches and a valid `cell_sel`.
- `bad_sel` out 1: last accepted `cell_sel` was invalid.
- `err_count` out 5: mismatches in the last run, 0..16.
- `fail_vec` out 4: first mismatching vector; 0 if none.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Reset behaviour:
  - Any cycle with `rst`=1 forces IDLE; all outputs go to 0, counters clear.
  - `rst` has priority over `start`.
  - Reset mid-run abandons the run without a `done` pulse.
- IDLE with `start`=1:
  - Latch `cell_sel`; clear `pass`, `bad_sel`, `err_count` and `fail_vec`.
  - If the selection is valid: `vec_out` <= 0, settle counter <= 0, go to SETTLE.
  - If the selection is invalid: `bad_sel` <= 1, go to DONE.
- SETTLE: increment the settle counter; after `SETTLE_CYCLES` cycles in SETTLE, go to SAMPLE.
- SAMPLE (one cycle):
  - Compare `dut_out` with golden(`cell_sel`, `vec_out`).
  - On mismatch: `err_count`++; if this is the first mismatch, `fail_vec` <= `vec_out`.
  - If `vec_out` = 2^arity − 1, go to DONE.
  - Otherwise `vec_out`++, reset the settle counter and go to SETTLE.
- DONE (one cycle):
  - `done`=1; `pass` <= (`err_count`==0 including this run's last compare) && !`bad_sel`.
  - `vec_out` <= 0; go to IDLE.
- `start` while `busy` is ignored and has no effect on the run.
- Arity is 1, 2, 3, 4, 2, 3, 3, 4, 3, 4 for selections 0..9. N = 2^arity.
- `err_count` saturates at 16; this is unreachable with 4 inputs but must not wrap.
- Results hold until the next accepted `start` or `rst`.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- Vector k is driven from cycle k·(S+1)+1 and sampled in cycle (k+1)·(S+1), where S = `SETTLE_CYCLES`.
- `done` is high in cycle N·(S+1)+1.
- With an invalid `cell_sel`, `done` is high in cycle 1.
- `vec_out` is registered: it changes only on SETTLE entry from IDLE/SAMPLE, and returns to 0 on leaving DONE.
- `pass`, `err_count` and `fail_vec` are valid from the `done` cycle onward.
- A new `start` is accepted in the cycle after `done`.

## Configuration
- `CELL_CHK_STOP_ON_FAIL_EN` defined: the first mismatch in SAMPLE goes directly to DONE, and remaining vectors are skipped (`err_count` = 1).
- Macro undefined: all N vectors are always applied and every mismatch is counted.

## Structure
- Package `cell_chk_pkg` holds:
  - enum `cell_sel_e` with values 0..9;
  - constant `CELL_NUM` = 10;
  - function `cell_arity(sel)`;
  - function `cell_golden(sel, vec)` implementing the ten cell equations (e.g. aoi21: ~((in0&in1)|in2), oai22: ~((in0|in1)&(in2|in3))).
- One sub-module, `cell_golden_model`: combinational wrapper around `cell_golden`, instantiated once. The FSM, counters and result registers stay in the top level.

## Test plan
- nand2_1 (sel 1), S=2, DUT model correct → `done` in cycle 13, `pass`=1, `err_count`=0, `fail_vec`=0; vec_out sequence 0,1,2,3.
- nand2_1, `dut_out` stuck at 0 → `err_count`=3, `fail_vec`=0, `pass`=0; with `CELL_CHK_STOP_ON_FAIL_EN` → `done` in cycle 4, `err_count`=1.
- aoi22_1 (sel 7), S=2, correct model → `done` in cycle 49, `pass`=1, `vec_out[3:0]` walks 0..15; inv_1 → `done` in cycle 7, `vec_out[3:1]`=0 throughout.
- `cell_sel`=12 → `done` in cycle 1, `bad_sel`=1, `pass`=0, `vec_out` stays 0.
- oai21_1 run with `start` pulsed again at cycle 5 → ignored, `done` still in cycle 25.
- `rst` asserted in cycle 6 of an oai22_1 run → next cycle all outputs 0, state IDLE, no `done`; a new `start` then completes normally.
